load_store_unit: RTL and testbench

- Responder for the decoder's memory-control outputs (MemRead/MemWrite).
- Sits in the MEM stage between the datapath and the data-memory port.
- Turns one load/store per instruction into a req/gnt/rvalid data-memory transaction: byte enables, store-data lane replication, load sign/zero extension, alignment checks.
- Stalls the pipeline until the access completes.

---
 rtl/load_store_unit.sv | 231 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit -- MEM-stage load/store responder.
//
// Turns one load or store per instruction into a req/gnt/rvalid transaction
// on the data-memory port. Builds byte enables and lane-replicated store
// data, extracts and sign/zero-extends load data, rejects misaligned or
// illegal accesses, and stalls the pipeline until the access completes.
//
// Optional build macro: LSU_TIMEOUT_EN
//   When defined, a watchdog aborts an access that spends TIMEOUT_CYCLES
//   cycles in REQ/WAIT. The access then completes with access_err and
//   rdata_valid, and loads return 0.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   mem_read          load request from control
//   mem_write         store request from control
//   funct3            size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr              effective byte address
//   wdata             store data
//   stall             hold pipeline (inputs stable while high)
//   rdata             extended load result
//   rdata_valid       one-cycle pulse, access complete
//   access_err        one-cycle pulse, illegal/misaligned access or timeout
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata   data-memory request
//   dm_gnt            request accepted this cycle
//   dm_rvalid/dm_rdata  read response
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        access_err,
  output logic        dm_req,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        load_q;

  logic        access;
  logic        illegal;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [31:0] lane;
  logic [31:0] ext;
  logic        tmo_hit;

  if (TIMEOUT_CYCLES == 0) begin : g_tmo_chk
    $error("load_store_unit: TIMEOUT_CYCLES must be nonzero");
  end

  // Request decode: legality, byte enables and store-lane replication.
  // A simultaneous read and write is treated as a read.
  always_comb begin
    access  = mem_read | mem_write;
    illegal = 1'b0;
    if (mem_read) begin
      illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    end else begin
      illegal = (funct3 >= 3'b011);
    end
    if (funct3[1:0] == 2'b01 && addr[0]) begin
      illegal = 1'b1;
    end
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) begin
      illegal = 1'b1;
    end

    be_c    = 4'b1111;
    wdata_c = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_c    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = wdata;
      end
    endcase
  end

  // Load data: shift the addressed lane down, then extend per saved funct3.
  always_comb begin
    lane = dm_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ext = {{24{lane[7]}}, lane[7:0]};
      3'b100:  ext = {24'h0, lane[7:0]};
      3'b001:  ext = {{16{lane[15]}}, lane[15:0]};
      3'b101:  ext = {16'h0, lane[15:0]};
      default: ext = dm_rdata;
    endcase
  end

  // Stall is raised combinationally on the IDLE cycle of a legal access so
  // the pipeline holds before the request is even registered.
  always_comb begin
    stall = rst_n && ((state == S_REQ) || (state == S_WAIT) ||
                      ((state == S_IDLE) && access && !illegal));
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == S_IDLE) begin
      tmo_cnt <= '0;
    end else if (state == S_REQ || state == S_WAIT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Fires on the last permitted REQ/WAIT cycle, so the abort lands after
  // exactly TIMEOUT_CYCLES cycles of waiting.
  always_comb begin
    tmo_hit = (state == S_REQ || state == S_WAIT) &&
              (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
  end
`else
  always_comb begin
    tmo_hit = 1'b0;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      dm_req      <= 1'b0;
      dm_we       <= 1'b0;
      dm_be       <= '0;
      dm_addr     <= '0;
      dm_wdata    <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      access_err  <= 1'b0;
      off_q       <= '0;
      f3_q        <= '0;
      load_q      <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      access_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (access) begin
            if (illegal) begin
              access_err <= 1'b1;
            end else begin
              dm_req   <= 1'b1;
              dm_we    <= !mem_read;
              dm_be    <= be_c;
              dm_addr  <= {addr[31:2], 2'b00};
              dm_wdata <= wdata_c;
              off_q    <= addr[1:0];
              f3_q     <= funct3;
              load_q   <= mem_read;
              state    <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (dm_gnt) begin
            dm_req <= 1'b0;
            if (load_q) begin
              state <= S_WAIT;
            end else begin
              state       <= S_DONE;
              rdata_valid <= 1'b1;
            end
          end else if (tmo_hit) begin
            dm_req      <= 1'b0;
            state       <= S_DONE;
            rdata_valid <= 1'b1;
            access_err  <= 1'b1;
            if (load_q) begin
              rdata <= '0;
            end
          end
        end
        S_WAIT: begin
          if (dm_rvalid) begin
            rdata       <= ext;
            state       <= S_DONE;
            rdata_valid <= 1'b1;
          end else if (tmo_hit) begin
            state       <= S_DONE;
            rdata_valid <= 1'b1;
            access_err  <= 1'b1;
            rdata       <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  a_no_read_write: assert property (@(posedge clk) disable iff (!rst_n)
    !((state == S_IDLE) && mem_read && mem_write));

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        rdata_valid, access_err;
  logic        dm_req, dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;

  int checks = 0;
  int failures = 0;

  // Per-access observations
  int          r_stall, r_req, r_done;
  logic        r_err, r_rdv, r_stable, r_we;
  logic [3:0]  r_be;
  logic [31:0] r_addr, r_wdata;

  load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .access_err(access_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid),
    .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Presents one access starting on the next IDLE cycle and plays a memory
  // that grants after gnt_dly request cycles and returns rword rv_dly cycles
  // after the grant. The instruction is withdrawn after any cycle where
  // stall is low, as the pipeline would. Cycle 0 is the IDLE cycle.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int gnt_dly, input int rv_dly,
                           input logic [31:0] rword);
    int   req_seen = 0;
    int   gnt_at = -1;
    logic fin = 1'b0;
    logic consumed;
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    r_stall = 0; r_req = 0; r_done = -1; r_err = 0; r_rdv = 0; r_stable = 1;
    r_we = 0; r_be = '0; r_addr = '0; r_wdata = '0;
    for (int k = 0; k < 40 && !fin; k++) begin
      @(negedge clk);
      if (stall) r_stall++;
      if (dm_req) begin
        if (r_req == 0) begin
          r_addr = dm_addr; r_be = dm_be; r_wdata = dm_wdata; r_we = dm_we;
        end else if (dm_addr !== r_addr || dm_be !== r_be ||
                     dm_wdata !== r_wdata || dm_we !== r_we) begin
          r_stable = 1'b0;
        end
        r_req++;
      end
      if (rdata_valid || access_err) begin
        fin = 1'b1; r_done = k; r_err = access_err; r_rdv = rdata_valid;
      end
      dm_gnt = 1'b0; dm_rvalid = 1'b0;
      if (dm_req && req_seen >= gnt_dly) begin
        dm_gnt = 1'b1; gnt_at = k;
      end
      if (dm_req) req_seen++;
      if (gnt_at >= 0 && k - gnt_at == rv_dly) begin
        dm_rvalid = 1'b1; dm_rdata = rword;
      end
      consumed = !stall;
      if (!fin) begin
        @(posedge clk); #1;
        if (consumed) begin mem_read = 1'b0; mem_write = 1'b0; end
      end
    end
    dm_gnt = 1'b0; dm_rvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = '0; wdata = '0;
    dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_req", dm_req, 0);
    check("rst_be", dm_be, 0);
    check("rst_addr", dm_addr, 0);
    check("rst_rdata", rdata, 0);
    check("rst_flags", {rdata_valid, access_err}, 0);
    mem_read = 1'b0;
    rst_n = 1'b1;

    // SW, grant in the first request cycle
    do_access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 1, 0);
    check("sw_addr", r_addr, 32'h100);
    check("sw_be", r_be, 4'b1111);
    check("sw_wdata", r_wdata, 32'hDEADBEEF);
    check("sw_we", r_we, 1);
    check("sw_stall", r_stall, 2);
    check("sw_done", r_done, 2);
    check("sw_rdv", {r_rdv, r_err}, 2'b10);
    check("sw_rdata", rdata, 0);

    // Loads with zero-wait memory
    do_access(1, 0, 3'b000, 32'h103, 0, 0, 1, 32'h80112233);
    check("lb_rdata", rdata, 32'hFFFFFF80);
    check("lb_be", r_be, 4'b1000);
    check("lb_addr", r_addr, 32'h100);
    check("lb_we", r_we, 0);
    check("lb_done", r_done, 3);
    check("lb_stall", r_stall, 3);
    do_access(1, 0, 3'b100, 32'h103, 0, 0, 1, 32'h80112233);
    check("lbu_rdata", rdata, 32'h00000080);
    do_access(1, 0, 3'b101, 32'h102, 0, 0, 1, 32'h80112233);
    check("lhu_rdata", rdata, 32'h00008011);
    check("lhu_be", r_be, 4'b1100);
    do_access(1, 0, 3'b001, 32'h102, 0, 0, 1, 32'h80112233);
    check("lh_rdata", rdata, 32'hFFFF8011);
    do_access(1, 0, 3'b000, 32'h101, 0, 0, 1, 32'h80112233);
    check("lb1_rdata", rdata, 32'h00000022);
    check("lb1_be", r_be, 4'b0010);

    // Sub-word stores
    do_access(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 0, 1, 0);
    check("sh_addr", r_addr, 32'h200);
    check("sh_be", r_be, 4'b1100);
    check("sh_wdata", r_wdata, 32'hABCDABCD);
    check("sh_rdata_kept", rdata, 32'h00000022);
    do_access(0, 1, 3'b000, 32'h201, 32'h0000005A, 0, 1, 0);
    check("sb_be", r_be, 4'b0010);
    check("sb_wdata", r_wdata, 32'h5A5A5A5A);

    // Illegal accesses
    do_access(1, 0, 3'b010, 32'h101, 0, 0, 1, 32'h11111111);
    check("lw_mis_err", {r_err, r_rdv}, 2'b10);
    check("lw_mis_req", r_req, 0);
    check("lw_mis_stall", r_stall, 0);
    check("lw_mis_done", r_done, 1);
    check("lw_mis_rdata", rdata, 32'h00000022);
    do_access(0, 1, 3'b001, 32'h203, 32'h1234, 0, 1, 0);
    check("sh_mis_err", {r_err, r_rdv}, 2'b10);
    check("sh_mis_req", r_req, 0);
    check("sh_mis_stall", r_stall, 0);
    do_access(0, 1, 3'b100, 32'h0, 32'h1234, 0, 1, 0);
    check("s_f3_err", {r_err, r_rdv, r_req[0]}, 3'b100);

    // LW with delayed grant and response
    do_access(1, 0, 3'b010, 32'h40, 0, 3, 2, 32'h12345678);
    check("lwd_req", r_req, 4);
    check("lwd_stable", r_stable, 1);
    check("lwd_addr", r_addr, 32'h40);
    check("lwd_stall", r_stall, 7);
    check("lwd_done", r_done, 7);
    check("lwd_rdata", rdata, 32'h12345678);

    // Reset while waiting for read data
    @(posedge clk); #1;
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h80;
    @(posedge clk); #1;
    @(negedge clk);
    check("rw_req_pre", dm_req, 1);
    dm_gnt = 1'b1;
    @(posedge clk); #1;
    dm_gnt = 1'b0;
    @(negedge clk);
    check("rw_wait_stall", stall, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rw_rst_stall", stall, 0);
    check("rw_rst_req", dm_req, 0);
    mem_read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dm_rvalid = 1'b1; dm_rdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    dm_rvalid = 1'b0;
    @(negedge clk);
    check("rw_late_rdata", rdata, 0);
    check("rw_late_flags", {rdata_valid, stall, dm_req}, 0);

    // Recovery after reset
    do_access(1, 0, 3'b010, 32'h10, 0, 0, 1, 32'hA5A50001);
    check("rec_rdata", rdata, 32'hA5A50001);
    check("rec_done", r_done, 3);

`ifdef LSU_TIMEOUT_EN
    do_access(1, 0, 3'b010, 32'h300, 0, 1000, 1, 32'hFFFFFFFF);
    check("tmo_req", r_req, 8);
    check("tmo_done", r_done, 9);
    check("tmo_flags", {r_err, r_rdv}, 2'b11);
    check("tmo_rdata", rdata, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
